sequencer_datapath: RTL and testbench

//  Datapath end of the drum-sequencer control FSM. It consumes ld_ins1..4, ld_bpm, play and timing.

---
 rtl/sequencer_datapath.sv | 126 ++++++++++++
 tb/tb_sequencer_datapath.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer_datapath.sv
// Drum-sequencer datapath: four 8-step patterns, a BPM register, a
// phase-accumulator step tick, and per-step instrument trigger pulses.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   data_in    pattern bits (bit0 = step 1) or BPM value
//   ld_ins1..4 load data_in into pattern 1..4
//   ld_bpm     load data_in into BPM (0 is stored as 1, flags bpm_err)
//   play       playback enable for the step generator
//   timing     current step from control (0 idle, 1..8 step)
//   step_tick  one-clk pulse per eighth-note step
//   trig       one-clk trigger per instrument (trig[i-1] = instrument i)
//   step_led   one-hot current step, 0 outside 1..8
//   bpm_err    sticky flag: last BPM load attempted 0
module sequencer_datapath #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned BPM_RST = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       ld_ins1,
  input  logic       ld_ins2,
  input  logic       ld_ins3,
  input  logic       ld_ins4,
  input  logic       ld_bpm,
  input  logic       play,
  input  logic [3:0] timing,
  output logic       step_tick,
  output logic [3:0] trig,
  output logic [7:0] step_led,
  output logic       bpm_err
);

  localparam logic [63:0] THRESH_L =
    64'(CLK_HZ) * 64'd60;
  localparam logic [ACC_W-1:0] THRESH =
    ACC_W'(THRESH_L);
  localparam logic [7:0] BPM_INIT = 8'(BPM_RST);

  logic [3:0][7:0]   pat;
  logic [7:0]        bpm;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W-1:0]  sum;
  logic [3:0]        timing_q;
  logic              in_range;
  logic              evt;
  logic [2:0]        idx;
  logic [3:0]        hit;
  logic [7:0]        onehot;

  // Increment is 2*bpm so that THRESH = CLK_HZ*60 yields
  // eighth notes (two steps per beat) with no rounding drift.
  assign inc = {{(ACC_W-9){1'b0}}, bpm, 1'b0};
  assign sum = acc + inc;

  assign in_range = (timing != 4'd0) && (timing <= 4'd8);
  assign evt      = in_range && (timing != timing_q);
  assign idx      = 3'(timing - 4'd1);
  assign onehot   = 8'd1 << idx;

  always_comb begin
    hit = 4'd0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = pat[i][idx];
    end
  end

  // Pattern and BPM registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat     <= '0;
      bpm     <= BPM_INIT;
      bpm_err <= 1'b0;
    end else begin
      if (ld_ins1) pat[0] <= data_in;
      if (ld_ins2) pat[1] <= data_in;
      if (ld_ins3) pat[2] <= data_in;
      if (ld_ins4) pat[3] <= data_in;
      if (ld_bpm) begin
        if (data_in == 8'd0) begin
          bpm     <= 8'd1;
          bpm_err <= 1'b1;
        end else begin
          bpm     <= data_in;
          bpm_err <= 1'b0;
        end
      end
    end
  end

  // Step generator: acc keeps the remainder past THRESH,
  // so the long-run period is exact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      step_tick <= 1'b0;
    end else if (!play) begin
      acc       <= '0;
      step_tick <= 1'b0;
    end else if (sum >= THRESH) begin
      acc       <= sum - THRESH;
      step_tick <= 1'b1;
    end else begin
      acc       <= sum;
      step_tick <= 1'b0;
    end
  end

  // Trigger and LED path
  always_ff @(posedge clk) begin
    if (!reset) begin
      timing_q <= 4'd0;
      trig     <= 4'd0;
      step_led <= 8'd0;
    end else begin
      timing_q <= timing;
      trig     <= evt ? hit : 4'd0;
      step_led <= in_range ? onehot : 8'd0;
    end
  end

endmodule

// File: tb/tb_sequencer_datapath.sv
// Randomised scoreboard bench for sequencer_datapath.
// Driver pushes per-cycle expectations; monitor pops and compares.
module tb_sequencer_datapath;

  localparam int     HZ = 60;
  localparam longint T  = 3600;

  typedef struct packed {
    logic       tick;
    logic [3:0] trig;
    logic [7:0] led;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       ld_ins1 = 1'b0;
  logic       ld_ins2 = 1'b0;
  logic       ld_ins3 = 1'b0;
  logic       ld_ins4 = 1'b0;
  logic       ld_bpm = 1'b0;
  logic       play = 1'b0;
  logic [3:0] timing = 4'd0;
  logic       step_tick;
  logic [3:0] trig;
  logic [7:0] step_led;
  logic       bpm_err;

  sequencer_datapath #(
    .CLK_HZ (HZ),
    .ACC_W  (32),
    .BPM_RST(120)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .ld_ins1  (ld_ins1),
    .ld_ins2  (ld_ins2),
    .ld_ins3  (ld_ins3),
    .ld_ins4  (ld_ins4),
    .ld_bpm   (ld_bpm),
    .play     (play),
    .timing   (timing),
    .step_tick(step_tick),
    .trig     (trig),
    .step_led (step_led),
    .bpm_err  (bpm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int trig0_seen = 0;
  int trig_any_seen = 0;
  exp_t q[$];
  exp_t me;

  // Reference state: cumulative phase since play rose;
  // a tick is each crossing of a multiple of T.
  logic [7:0] m_pat[4];
  int         m_bpm = 120;
  logic       m_err = 1'b0;
  longint     m_p = 0;
  int         m_tq = 0;

  task automatic chk(input string n,
                     input logic [7:0] a,
                     input logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               n, a, x, $time);
    end
  endtask

  task automatic chk_int(input string n,
                         input int a,
                         input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               n, a, x, $time);
    end
  endtask

  task automatic step(input logic       r,
                      input logic [7:0] d,
                      input logic [3:0] ld,
                      input logic       lb,
                      input logic       pl,
                      input int         tm);
    exp_t   e;
    longint inc;
    @(negedge clk);
    reset   = r;
    data_in = d;
    ld_ins1 = ld[0];
    ld_ins2 = ld[1];
    ld_ins3 = ld[2];
    ld_ins4 = ld[3];
    ld_bpm  = lb;
    play    = pl;
    timing  = 4'(tm);
    e = '0;
    if (!r) begin
      for (int i = 0; i < 4; i++) m_pat[i] = 8'd0;
      m_bpm = 120;
      m_err = 1'b0;
      m_p   = 0;
      m_tq  = 0;
    end else begin
      inc = 2 * m_bpm;
      e.tick = pl && (((m_p + inc) / T) != (m_p / T));
      m_p = pl ? m_p + inc : 0;
      if (tm >= 1 && tm <= 8) begin
        e.led = 8'(1 << (tm - 1));
        if (tm != m_tq) begin
          for (int i = 0; i < 4; i++)
            e.trig[i] = m_pat[i][tm-1];
        end
      end
      for (int i = 0; i < 4; i++)
        if (ld[i]) m_pat[i] = d;
      if (lb) begin
        m_bpm = (d == 0) ? 1 : int'(d);
        m_err = (d == 0);
      end
      m_tq = tm;
    end
    e.err = m_err;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("step_tick", {7'd0, step_tick}, {7'd0, me.tick});
      chk("trig", {4'd0, trig}, {4'd0, me.trig});
      chk("step_led", step_led, me.led);
      chk("bpm_err", {7'd0, bpm_err}, {7'd0, me.err});
      if (step_tick) tick_seen++;
      if (trig[0]) trig0_seen++;
      if (trig != 4'd0) trig_any_seen++;
    end
  end

  task automatic idle();
    step(1'b1, 8'd0, 4'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic ld_bpm_val(input logic [7:0] v,
                            input logic pl);
    step(1'b1, v, 4'd0, 1'b1, pl, 0);
  endtask

  // Count ticks over n play cycles starting from acc = 0.
  task automatic window(input string n,
                        input int cyc,
                        input int want);
    int c0;
    idle();
    c0 = tick_seen;
    repeat (cyc) step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, 0);
    idle();
    chk_int(n, tick_seen - c0, want);
  endtask

  initial begin : main
    int c0;
    int tm;
    logic r, lb, pl;
    logic [3:0] ld;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) m_pat[i] = 8'd0;

    // Reset overrides loads and play
    repeat (4) step(1'b0, 8'hFF, 4'hF, 1'b1, 1'b1, 3);

    // Reset BPM of 120 -> period 15
    window("tick_bpm_rst", 30, 2);

    // Reset cleared patterns: no triggers on a walk
    c0 = trig_any_seen;
    for (int t = 1; t <= 8; t++)
      step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, t);
    idle();
    chk_int("trig_after_rst", trig_any_seen - c0, 0);

    // BPM 60 -> first tick after 30 clks
    ld_bpm_val(8'd60, 1'b0);
    window("tick_bpm60_29", 29, 0);
    window("tick_bpm60_90", 90, 3);

    // BPM 7 -> exactly 14 ticks per 3600 clks
    ld_bpm_val(8'd7, 1'b0);
    window("tick_bpm7", 3600, 14);

    // Pattern 1 = 1000_0101 -> trig at steps 1, 3, 8
    step(1'b1, 8'h85, 4'b0001, 1'b0, 1'b0, 0);
    c0 = trig0_seen;
    for (int t = 1; t <= 8; t++)
      repeat (2) step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, t);
    idle();
    chk_int("trig0_pulses", trig0_seen - c0, 3);

    // BPM 0 -> stored as 1, error flagged
    ld_bpm_val(8'd0, 1'b0);
    window("tick_bpm0", 1800, 1);
    ld_bpm_val(8'd100, 1'b0);

    // Mid-play BPM change and play drop
    ld_bpm_val(8'd60, 1'b0);
    repeat (45) step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, 0);
    ld_bpm_val(8'd120, 1'b1);
    repeat (40) step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, 0);
    repeat (3) idle();

    // Random traffic
    pl = 1'b1;
    tm = 0;
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      ld = 4'd0;
      for (int i = 0; i < 4; i++)
        ld[i] = ($urandom_range(0, 19) == 0);
      lb = ($urandom_range(0, 29) == 0);
      d  = ($urandom_range(0, 7) == 0) ?
           8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) pl = ~pl;
      if ($urandom_range(0, 2) == 0)
        tm = ($urandom_range(0, 5) == 0) ?
             int'($urandom_range(0, 15)) :
             (tm % 8) + 1;
      step(r, d, ld, lb, pl, tm);
    end

    // Reset mid-pattern with a trigger pending
    step(1'b1, 8'hFF, 4'hF, 1'b0, 1'b0, 0);
    for (int t = 1; t <= 4; t++)
      step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, t);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 5);
    c0 = trig_any_seen;
    for (int t = 1; t <= 8; t++)
      step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, t);
    step(1'b1, 8'd0, 4'd0, 1'b0, 1'b1, 1);
    idle();
    chk_int("trig_after_mid_rst",
            trig_any_seen - c0, 0);

    @(posedge clk);
    #2;
    chk_int("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
